// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide stage.
package muldiv_pkg;

  localparam int MULDIV_WIDTH      = 32;
  localparam int MULDIV_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // op[0] clear marks the signed variants, op[1] set marks divide.
  function automatic logic isSignedOp(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic isDivOp(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request, status and writeback bundle between the control path and muldiv_unit.
interface muldiv_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  start;
  logic                  flush;
  logic [1:0]            op;
  logic [WIDTH-1:0]      srcA;
  logic [WIDTH-1:0]      srcB;
  logic [REG_ADDR_W-1:0] destReg;
  logic                  busy;
  logic                  done;
  logic                  wbWrite;
  logic [REG_ADDR_W-1:0] wbReg;
  logic [WIDTH-1:0]      wbData;
  logic [WIDTH-1:0]      hi;
  logic [WIDTH-1:0]      lo;

  modport master (
    output start, flush, op, srcA, srcB, destReg,
    input  busy, done, wbWrite, wbReg, wbData, hi, lo
  );

  modport slave (
    input  start, flush, op, srcA, srcB, destReg,
    output busy, done, wbWrite, wbReg, wbData, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_isDiv,
  input  logic [WIDTH-1:0] i_accHi,
  input  logic [WIDTH-1:0] i_accLo,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_accHi,
  output logic [WIDTH-1:0] o_accLo
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  // The trial difference is one bit wider than the remainder; its top bit is the borrow.
  always_comb begin
    w_sum     = {1'b0, i_accHi} + (i_accLo[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
    w_shifted = {i_accHi, i_accLo[WIDTH-1]};
    w_diff    = w_shifted - {1'b0, i_opnd};
    if (i_isDiv) begin
      o_accHi = w_diff[WIDTH] ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
      o_accLo = {i_accLo[WIDTH-2:0], ~w_diff[WIDTH]};
    end else begin
      o_accHi = w_sum[WIDTH:1];
      o_accLo = {w_sum[0], i_accLo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU stage with HI/LO result registers and a one-cycle
// register-file writeback pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = MULDIV_WIDTH,
  parameter int REG_ADDR_W = MULDIV_REG_ADDR_W
) (
  input  logic     clock,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t                r_state;
  logic [CNT_W-1:0]      r_count;
  logic [1:0]            r_op;
  logic                  r_signA;
  logic                  r_signB;
  logic [WIDTH-1:0]      r_opnd;
  logic [WIDTH-1:0]      r_accHi;
  logic [WIDTH-1:0]      r_accLo;
  logic [WIDTH-1:0]      r_hi;
  logic [WIDTH-1:0]      r_lo;
  logic [REG_ADDR_W-1:0] r_destReg;

  logic [WIDTH-1:0]      w_magA;
  logic [WIDTH-1:0]      w_magB;
  logic                  w_divZero;
  logic [WIDTH-1:0]      w_stepHi;
  logic [WIDTH-1:0]      w_stepLo;
  logic [WIDTH-1:0]      w_fixHi;
  logic [WIDTH-1:0]      w_fixLo;
  logic [2*WIDTH-1:0]    w_negProd;
  logic                  w_done;

  assign w_magA    = (isSignedOp(bus.op) && bus.srcA[WIDTH-1]) ? -bus.srcA : bus.srcA;
  assign w_magB    = (isSignedOp(bus.op) && bus.srcB[WIDTH-1]) ? -bus.srcB : bus.srcB;
  assign w_divZero = isDivOp(bus.op) && (bus.srcB == '0);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_isDiv (isDivOp(r_op)),
    .i_accHi (r_accHi),
    .i_accLo (r_accLo),
    .i_opnd  (r_opnd),
    .o_accHi (w_stepHi),
    .o_accLo (w_stepLo)
  );

  // Sign fixup: divide negates quotient on differing signs and remainder on a negative dividend.
  assign w_negProd = -{r_accHi, r_accLo};
  always_comb begin
    w_fixHi = r_accHi;
    w_fixLo = r_accLo;
    if (isSignedOp(r_op)) begin
      if (isDivOp(r_op)) begin
        if (r_signA ^ r_signB) w_fixLo = -r_accLo;
        if (r_signA)           w_fixHi = -r_accHi;
      end else if (r_signA ^ r_signB) begin
        {w_fixHi, w_fixLo} = w_negProd;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_op      <= '0;
      r_signA   <= 1'b0;
      r_signB   <= 1'b0;
      r_opnd    <= '0;
      r_accHi   <= '0;
      r_accLo   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_destReg <= '0;
    end else if (bus.flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_state <= ST_IDLE;
          if (bus.start) begin
            r_op      <= bus.op;
            r_destReg <= bus.destReg;
            r_signA   <= bus.srcA[WIDTH-1];
            r_signB   <= bus.srcB[WIDTH-1];
            r_count   <= '0;
            r_accHi   <= '0;
            if (w_divZero) begin
              r_state <= ST_DONE;
              r_hi    <= bus.srcA;
              r_lo    <= '1;
            end else begin
              // Divide keeps the dividend in the low accumulator; multiply keeps the multiplier there.
              r_state <= ST_CALC;
              r_opnd  <= isDivOp(bus.op) ? w_magB : w_magA;
              r_accLo <= isDivOp(bus.op) ? w_magA : w_magB;
            end
          end
        end
        ST_CALC: begin
          r_accHi <= w_stepHi;
          r_accLo <= w_stepLo;
          r_count <= r_count + CNT_W'(1);
          if (r_count == CNT_W'(WIDTH-1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_hi    <= w_fixHi;
          r_lo    <= w_fixLo;
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_done      = (r_state == ST_DONE);
  assign bus.busy    = (r_state == ST_CALC) || (r_state == ST_FIX);
  assign bus.done    = w_done;
  assign bus.wbWrite = w_done;
  assign bus.wbReg   = r_destReg;
  assign bus.wbData  = r_lo;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;

endmodule
